// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared raster timing constants and width helper
// Purpose : standard VGA/SVGA timing sets and a counter width helper used by
//           vga_timing_gen to size and sanity-check its counters.
// Ports   : none (package)
package vga_timing_gen_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_pulse;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_pulse;
    int unsigned v_back;
    bit          h_polarity;
    bit          v_polarity;
  } vga_timing_t;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam vga_timing_t TIMING_640X480_60 = '{
    h_active: 640, h_front: 16, h_pulse: 96,  h_back: 48,
    v_active: 480, v_front: 10, v_pulse: 2,   v_back: 33,
    h_polarity: 1'b0, v_polarity: 1'b0
  };

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam vga_timing_t TIMING_800X600_60 = '{
    h_active: 800, h_front: 40, h_pulse: 128, h_back: 88,
    v_active: 600, v_front: 1,  v_pulse: 4,   v_back: 23,
    h_polarity: 1'b1, v_polarity: 1'b1
  };

  // Bits needed to hold the values 0..total-1, never less than one bit.
  function automatic int unsigned counter_width(input int unsigned total);
    int unsigned w;
    w = $clog2(total);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and consumers
// Purpose : carries pixel coordinates and sync/blank/strobe signals.
// Signals : x, y        coordinates (undelayed)
//           hsync, vsync, blank, line_start, frame_start  timing (optionally delayed)
// Modports: master (generator drives), slave (pattern generator / serializer reads)
interface vga_timing_gen_if #(
  parameter int unsigned BITS_X = 10,
  parameter int unsigned BITS_Y = 10
);

  logic [BITS_X-1:0] x;
  logic [BITS_Y-1:0] y;
  logic              hsync;
  logic              vsync;
  logic              blank;
  logic              line_start;
  logic              frame_start;

  modport master (
    output x, y, hsync, vsync, blank, line_start, frame_start
  );

  modport slave (
    input x, y, hsync, vsync, blank, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// rtl/vga_timing_gen_sync_delay_line.sv - resettable fixed-depth shift register
// Purpose : delays a WIDTH-bit vector by DEPTH clocks; every stage resets to
//           RESET_VALUE. DEPTH=0 is a plain wire with no registers.
// Ports   : i_clk    clock
//           i_reset  synchronous active-high reset
//           i_data   vector in
//           o_data   vector out, DEPTH cycles later
module sync_delay_line #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       DEPTH       = 0,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = i_clk ^ i_reset;
      assign o_data = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VALUE;
          end
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator for the pixel clock domain
// Purpose : free-running horizontal/vertical counters producing coordinates,
//           sync, blank and line/frame strobes, all registered (1-cycle
//           latency). Sync/blank/strobes can be delayed by C_sync_delay extra
//           clocks to line up with a pipelined pixel source; x/y are not.
// Ports   : i_clk_pixel  pixel clock
//           i_reset      synchronous active-high reset
//           o_vga        vga_timing_gen_if.master: x, y, hsync, vsync, blank,
//                        line_start, frame_start
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned C_resolution_x      = TIMING_640X480_60.h_active,
  parameter int unsigned C_hsync_front_porch = TIMING_640X480_60.h_front,
  parameter int unsigned C_hsync_pulse       = TIMING_640X480_60.h_pulse,
  parameter int unsigned C_hsync_back_porch  = TIMING_640X480_60.h_back,
  parameter int unsigned C_resolution_y      = TIMING_640X480_60.v_active,
  parameter int unsigned C_vsync_front_porch = TIMING_640X480_60.v_front,
  parameter int unsigned C_vsync_pulse       = TIMING_640X480_60.v_pulse,
  parameter int unsigned C_vsync_back_porch  = TIMING_640X480_60.v_back,
  parameter bit          C_hsync_polarity    = TIMING_640X480_60.h_polarity,
  parameter bit          C_vsync_polarity    = TIMING_640X480_60.v_polarity,
  parameter int unsigned C_sync_delay        = 0,
  parameter int unsigned C_bits_x            = 10,
  parameter int unsigned C_bits_y            = 10
) (
  input  logic             i_clk_pixel,
  input  logic             i_reset,
  vga_timing_gen_if.master o_vga
);

  localparam int unsigned H_TOTAL  = C_resolution_x + C_hsync_front_porch
                                   + C_hsync_pulse + C_hsync_back_porch;
  localparam int unsigned V_TOTAL  = C_resolution_y + C_vsync_front_porch
                                   + C_vsync_pulse + C_vsync_back_porch;
  localparam int unsigned HS_START = C_resolution_x + C_hsync_front_porch;
  localparam int unsigned HS_END   = HS_START + C_hsync_pulse;
  localparam int unsigned VS_START = C_resolution_y + C_vsync_front_porch;
  localparam int unsigned VS_END   = VS_START + C_vsync_pulse;

  // Bit order of the delayed timing vector: {hsync, vsync, blank, line_start, frame_start}
  localparam logic [4:0] SYNC_RESET = {~C_hsync_polarity, ~C_vsync_polarity, 1'b1, 1'b0, 1'b0};

  generate
    if (C_bits_x < counter_width(H_TOTAL)) begin : g_bad_bits_x
      $error("vga_timing_gen: C_bits_x too narrow for H_TOTAL-1");
    end
    if (C_bits_y < counter_width(V_TOTAL)) begin : g_bad_bits_y
      $error("vga_timing_gen: C_bits_y too narrow for V_TOTAL-1");
    end
    if (C_hsync_pulse < 1 || C_vsync_pulse < 1) begin : g_bad_pulse
      $error("vga_timing_gen: sync pulse widths must be at least 1");
    end
  endgenerate

  logic [C_bits_x-1:0] r_hcnt;
  logic [C_bits_y-1:0] r_vcnt;

  logic [C_bits_x-1:0] r_x;
  logic [C_bits_y-1:0] r_y;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_blank;
  logic                r_line_start;
  logic                r_frame_start;

  // Counters are compared at 32 bits so sync end points equal to the total
  // (zero back porch) cannot alias through truncation.
  logic [31:0] w_hcnt_ext;
  logic [31:0] w_vcnt_ext;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_visible;
  logic        w_hsync_active;
  logic        w_vsync_active;
  logic [4:0]  w_sync_in;
  logic [4:0]  w_sync_out;

  assign w_hcnt_ext     = 32'(r_hcnt);
  assign w_vcnt_ext     = 32'(r_vcnt);
  assign w_h_last       = (w_hcnt_ext == H_TOTAL - 1);
  assign w_v_last       = (w_vcnt_ext == V_TOTAL - 1);
  assign w_visible      = (w_hcnt_ext < C_resolution_x) && (w_vcnt_ext < C_resolution_y);
  assign w_hsync_active = (w_hcnt_ext >= HS_START) && (w_hcnt_ext < HS_END);
  // vcnt only moves on the hcnt wrap, so vsync changes on whole-line boundaries.
  assign w_vsync_active = (w_vcnt_ext >= VS_START) && (w_vcnt_ext < VS_END);

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~C_hsync_polarity;
      r_vsync       <= ~C_vsync_polarity;
      r_blank       <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
      if (w_h_last) begin
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end
      r_x           <= r_hcnt;
      r_y           <= r_vcnt;
      r_hsync       <= w_hsync_active ? C_hsync_polarity : ~C_hsync_polarity;
      r_vsync       <= w_vsync_active ? C_vsync_polarity : ~C_vsync_polarity;
      r_blank       <= ~w_visible;
      r_line_start  <= (r_hcnt == '0);
      r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  assign w_sync_in = {r_hsync, r_vsync, r_blank, r_line_start, r_frame_start};

  sync_delay_line #(
    .WIDTH       (5),
    .DEPTH       (C_sync_delay),
    .RESET_VALUE (SYNC_RESET)
  ) u_sync_delay (
    .i_clk   (i_clk_pixel),
    .i_reset (i_reset),
    .i_data  (w_sync_in),
    .o_data  (w_sync_out)
  );

  assign o_vga.x           = r_x;
  assign o_vga.y           = r_y;
  assign o_vga.hsync       = w_sync_out[4];
  assign o_vga.vsync       = w_sync_out[3];
  assign o_vga.blank       = w_sync_out[2];
  assign o_vga.line_start  = w_sync_out[1];
  assign o_vga.frame_start = w_sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  typedef struct {
    int rx, hfp, hp, hbp;
    int ry, vfp, vp, vbp;
    int hpol, vpol, d;
  } cfg_t;

  typedef struct {
    int x, y, hs, vs, bl, ls, fs;
  } out_t;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  int cyc       = 0;
  bit rst_seen  = 1'b0;

  cfg_t cfg_a, cfg_b, cfg_c;

  vga_timing_gen_if #(.BITS_X(10), .BITS_Y(10)) if_a ();
  vga_timing_gen_if #(.BITS_X(4),  .BITS_Y(4))  if_b ();
  vga_timing_gen_if #(.BITS_X(4),  .BITS_Y(4))  if_c ();

  vga_timing_gen dut_a (
    .i_clk_pixel (clk),
    .i_reset     (reset),
    .o_vga       (if_a)
  );

  vga_timing_gen #(
    .C_resolution_x (8), .C_hsync_front_porch (2), .C_hsync_pulse (3), .C_hsync_back_porch (3),
    .C_resolution_y (6), .C_vsync_front_porch (1), .C_vsync_pulse (2), .C_vsync_back_porch (2),
    .C_hsync_polarity (1'b1), .C_vsync_polarity (1'b0), .C_sync_delay (0),
    .C_bits_x (4), .C_bits_y (4)
  ) dut_b (
    .i_clk_pixel (clk),
    .i_reset     (reset),
    .o_vga       (if_b)
  );

  vga_timing_gen #(
    .C_resolution_x (8), .C_hsync_front_porch (2), .C_hsync_pulse (3), .C_hsync_back_porch (3),
    .C_resolution_y (6), .C_vsync_front_porch (1), .C_vsync_pulse (2), .C_vsync_back_porch (2),
    .C_hsync_polarity (1'b0), .C_vsync_polarity (1'b1), .C_sync_delay (3),
    .C_bits_x (4), .C_bits_y (4)
  ) dut_c (
    .i_clk_pixel (clk),
    .i_reset     (reset),
    .o_vga       (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after `c` clean edges since the last reset edge (0 = the reset edge).
  // Coordinates show pixel c-1; delayed timing shows pixel c-1-d.
  function automatic out_t model(input cfg_t c, input int cy);
    out_t o;
    int ht, vt, n, m, xs, ys;
    ht = c.rx + c.hfp + c.hp + c.hbp;
    vt = c.ry + c.vfp + c.vp + c.vbp;
    o.x  = 0;
    o.y  = 0;
    o.hs = (c.hpol == 0) ? 1 : 0;
    o.vs = (c.vpol == 0) ? 1 : 0;
    o.bl = 1;
    o.ls = 0;
    o.fs = 0;
    if (cy > 0) begin
      n   = cy - 1;
      o.x = n % ht;
      o.y = (n / ht) % vt;
      m   = cy - 1 - c.d;
      if (m >= 0) begin
        xs   = m % ht;
        ys   = (m / ht) % vt;
        o.bl = (xs < c.rx && ys < c.ry) ? 0 : 1;
        if (xs >= c.rx + c.hfp && xs < c.rx + c.hfp + c.hp) o.hs = c.hpol;
        if (ys >= c.ry + c.vfp && ys < c.ry + c.vfp + c.vp) o.vs = c.vpol;
        o.ls = (xs == 0) ? 1 : 0;
        o.fs = (xs == 0 && ys == 0) ? 1 : 0;
      end
    end
    return o;
  endfunction

  task automatic check(input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", what, act, exp, cyc, $time);
    end
  endtask

  task automatic check_dut(input string nm, input cfg_t c, input int x, input int y,
                           input int hs, input int vs, input int bl, input int ls, input int fs);
    out_t e;
    e = model(c, cyc);
    check({nm, ".x"}, x, e.x);
    check({nm, ".y"}, y, e.y);
    check({nm, ".hsync"}, hs, e.hs);
    check({nm, ".vsync"}, vs, e.vs);
    check({nm, ".blank"}, bl, e.bl);
    check({nm, ".line_start"}, ls, e.ls);
    check({nm, ".frame_start"}, fs, e.fs);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      cyc      <= 0;
      rst_seen <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      check_dut("a", cfg_a, int'(if_a.x), int'(if_a.y), int'(if_a.hsync), int'(if_a.vsync),
                int'(if_a.blank), int'(if_a.line_start), int'(if_a.frame_start));
      check_dut("b", cfg_b, int'(if_b.x), int'(if_b.y), int'(if_b.hsync), int'(if_b.vsync),
                int'(if_b.blank), int'(if_b.line_start), int'(if_b.frame_start));
      check_dut("c", cfg_c, int'(if_c.x), int'(if_c.y), int'(if_c.hsync), int'(if_c.vsync),
                int'(if_c.blank), int'(if_c.line_start), int'(if_c.frame_start));
    end
  end

  int a_hs_low    = 0;
  int a_hs_first  = -1;
  int a_hs_last   = -1;
  int a_bl_cnt    = 0;
  int a_bl_first  = -1;
  int a_ls_prev   = -1;
  int a_ls_period = -1;
  int b_fs_prev   = -1;
  int b_fs_period = -1;
  int b_vs_cnt    = 0;
  int b_bl_cnt    = 0;
  int b_vs_frame  = -1;
  int b_bl_frame  = -1;
  int b_wrap_arm  = 0;
  int b_wrap_done = 0;
  int c_hs_mark   = -1;
  int found       = 0;

  initial begin
    cfg_a = '{rx: 640, hfp: 16, hp: 96, hbp: 48, ry: 480, vfp: 10, vp: 2, vbp: 33,
              hpol: 0, vpol: 0, d: 0};
    cfg_b = '{rx: 8, hfp: 2, hp: 3, hbp: 3, ry: 6, vfp: 1, vp: 2, vbp: 2,
              hpol: 1, vpol: 0, d: 0};
    cfg_c = '{rx: 8, hfp: 2, hp: 3, hbp: 3, ry: 6, vfp: 1, vp: 2, vbp: 2,
              hpol: 0, vpol: 1, d: 3};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_blank", int'(if_a.blank), 1);
    check("rst_a_hsync", int'(if_a.hsync), 1);
    check("rst_b_hsync", int'(if_b.hsync), 0);
    check("rst_c_vsync", int'(if_c.vsync), 0);
    check("rst_c_frame_start", int'(if_c.frame_start), 0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("first_a_x", int'(if_a.x), 0);
        check("first_a_y", int'(if_a.y), 0);
        check("first_a_blank", int'(if_a.blank), 0);
        check("first_a_hsync", int'(if_a.hsync), 1);
        check("first_a_vsync", int'(if_a.vsync), 1);
        check("first_a_line_start", int'(if_a.line_start), 1);
        check("first_a_frame_start", int'(if_a.frame_start), 1);
      end
      if (cyc >= 1 && cyc <= 4) begin
        check("c_hold_frame_start", int'(if_c.frame_start), (cyc == 4) ? 1 : 0);
        check("c_hold_blank", int'(if_c.blank), (cyc == 4) ? 0 : 1);
        check("c_hold_hsync", int'(if_c.hsync), 1);
      end

      if (if_a.y == 0) begin
        if (if_a.hsync == 1'b0) begin
          a_hs_low++;
          if (a_hs_first < 0) a_hs_first = int'(if_a.x);
          a_hs_last = int'(if_a.x);
        end
        if (if_a.blank) begin
          a_bl_cnt++;
          if (a_bl_first < 0) a_bl_first = int'(if_a.x);
        end
      end
      if (if_a.line_start) begin
        if (a_ls_prev >= 0) a_ls_period = cyc - a_ls_prev;
        a_ls_prev = cyc;
      end

      if (b_wrap_arm == 1 && b_wrap_done == 0) begin
        check("b_wrap_x", int'(if_b.x), 0);
        check("b_wrap_y", int'(if_b.y), 0);
        check("b_wrap_frame_start", int'(if_b.frame_start), 1);
        check("b_wrap_vsync", int'(if_b.vsync), 1);
        b_wrap_done = 1;
      end
      if (if_b.x == 4'd15 && if_b.y == 4'd10) b_wrap_arm = 1;

      if (if_b.frame_start) begin
        if (b_fs_prev >= 0 && b_fs_period < 0) begin
          b_fs_period = cyc - b_fs_prev;
          b_vs_frame  = b_vs_cnt;
          b_bl_frame  = b_bl_cnt;
        end
        b_fs_prev = cyc;
        b_vs_cnt  = 0;
        b_bl_cnt  = 0;
      end
      if (if_b.vsync == 1'b0) b_vs_cnt++;
      if (if_b.blank) b_bl_cnt++;

      if (c_hs_mark < 0 && if_c.x == 4'd10) c_hs_mark = cyc;
      if (c_hs_mark >= 0 && cyc == c_hs_mark + 2) check("c_hsync_before_fall", int'(if_c.hsync), 1);
      if (c_hs_mark >= 0 && cyc == c_hs_mark + 3) check("c_hsync_fall", int'(if_c.hsync), 0);

      if (if_a.x == 10'd300 && if_a.y == 10'd1) begin
        found = 1;
        break;
      end
    end

    check("reach_mid_frame", found, 1);
    check("a_hsync_low_cycles", a_hs_low, 96);
    check("a_hsync_first_x", a_hs_first, 656);
    check("a_hsync_last_x", a_hs_last, 751);
    check("a_blank_cycles", a_bl_cnt, 160);
    check("a_blank_first_x", a_bl_first, 640);
    check("a_line_period", a_ls_period, 800);
    check("b_frame_period", b_fs_period, 176);
    check("b_vsync_cycles", b_vs_frame, 32);
    check("b_blank_cycles", b_bl_frame, 128);
    check("b_wrap_seen", b_wrap_done, 1);

    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_a_x", int'(if_a.x), 0);
    check("mid_rst_a_y", int'(if_a.y), 0);
    check("mid_rst_a_blank", int'(if_a.blank), 1);
    check("mid_rst_a_hsync", int'(if_a.hsync), 1);
    check("mid_rst_a_line_start", int'(if_a.line_start), 0);
    check("mid_rst_a_frame_start", int'(if_a.frame_start), 0);
    check("mid_rst_b_hsync", int'(if_b.hsync), 0);
    check("mid_rst_c_blank", int'(if_c.blank), 1);
    reset = 1'b0;
    @(negedge clk);
    check("restart_a_x", int'(if_a.x), 0);
    check("restart_a_y", int'(if_a.y), 0);
    check("restart_a_frame_start", int'(if_a.frame_start), 1);
    check("restart_b_frame_start", int'(if_b.frame_start), 1);
    check("restart_c_frame_start", int'(if_c.frame_start), 0);

    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
